// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, line-locked sharing of one uart_tx between NREQ byte streams.
// Define UART_TX_ARB_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned MAX_BURST    = 256,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int unsigned IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW         = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned BW         = $clog2(MAX_BURST) + 1;
    localparam int unsigned IDLE_LAST  = LOCK_TIMEOUT - 1;
    localparam int unsigned BURST_LAST = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [BW-1:0]   bytes_q, bytes_d;

    logic            own_valid;
    logic            xfer;
    logic            release_lock;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;

    assign grant = grant_q;
    assign busy  = (state_q == S_LOCKED);

    // Pass-through of the owner's handshake while locked
    always_comb begin
        own_valid = req_valid[owner_q];
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == S_LOCKED) begin
            tx_valid           = own_valid;
            tx_data            = req_data[32'(owner_q) * 8 +: 8];
            req_ready[owner_q] = tx_ready;
        end
    end

`ifdef UART_TX_ARB_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_q;

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick_any = 1'b1;
                pick_idx = IW'(i);
            end
        end
    end
`else
    // Descending scan so the smallest offset after last wins
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % int'(NREQ)]) begin
                pick_any = 1'b1;
                pick_idx = IW'((int'(last_q) + k) % int'(NREQ));
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        grant_d      = grant_q;
        idle_d       = idle_q;
        bytes_d      = bytes_q;
        xfer         = tx_valid && tx_ready;
        release_lock = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d           = S_LOCKED;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    idle_d            = '0;
                    bytes_d           = '0;
                end
            end
            S_LOCKED: begin
                if (xfer && (bytes_q != '1)) bytes_d = bytes_q + BW'(1);
                if (own_valid)           idle_d = '0;
                else if (idle_q != '1)   idle_d = idle_q + TW'(1);
                release_lock = (xfer && (tx_data == EOL_CHAR))
                            || (!own_valid && (idle_q >= TW'(IDLE_LAST)))
                            || ((MAX_BURST != 0) && xfer && (bytes_q == BW'(BURST_LAST)));
                if (release_lock) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            grant_q <= '0;
            idle_q  <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            idle_q  <= idle_d;
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a cycle-level reference model of the
// arbitration rules plus per-requester byte-stream scoreboards.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned LT   = 16;
    localparam int unsigned MB   = 4;
    localparam logic [7:0]  EOL  = 8'h0A;
    localparam int          NCYC = 20000;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(NREQ), .LOCK_TIMEOUT(LT), .MAX_BURST(MB), .EOL_CHAR(EOL)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic            busy;
        logic            tx_valid;
        logic [7:0]      tx_data;
        logic [NREQ-1:0] req_ready;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src[NREQ][$];
    logic [7:0] sb[NREQ][$];
    int         errors = 0;
    int         checks = 0;
    int         xfers  = 0;

    // reference model: who owns the UART and how the current grant has gone so far
    bit m_locked;
    int m_owner, m_last, m_idle_run, m_sent;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    task automatic model_step(output logic [NREQ-1:0] acc);
        exp_t       e;
        logic [7:0] b;
        bit         moved;
        e   = '0;
        acc = '0;
        if (m_locked) begin
            b                   = req_data[m_owner*8 +: 8];
            e.grant[m_owner]    = 1'b1;
            e.busy              = 1'b1;
            e.tx_valid          = req_valid[m_owner];
            e.tx_data           = b;
            e.req_ready[m_owner] = tx_ready;
        end
        exp_q.push_back(e);
        if (!resetn) begin
            m_locked = 1'b0;
            m_last   = NREQ - 1;
        end else if (!m_locked) begin
`ifdef UART_TX_ARB_PRIO_EN
            for (int c = 0; c < NREQ; c++) begin
`else
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
`endif
                if (req_valid[c]) begin
                    m_locked   = 1'b1;
                    m_owner    = c;
                    m_idle_run = 0;
                    m_sent     = 0;
                    break;
                end
            end
        end else begin
            moved = req_valid[m_owner] && tx_ready;
            if (moved) begin
                acc[m_owner] = 1'b1;
                m_sent++;
            end
            if (req_valid[m_owner]) m_idle_run = 0;
            else                    m_idle_run++;
            if ((moved && b == EOL) || m_idle_run == LT || (MB != 0 && moved && m_sent == MB)) begin
                m_locked = 1'b0;
                m_last   = m_owner;
            end
        end
    endtask

    // Monitor: compare the DUT each cycle against the model and the byte scoreboards
    always @(negedge clk) begin
        exp_t       e;
        int         o;
        logic [7:0] want;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant",     32'(grant),     32'(e.grant));
            check("busy",      32'(busy),      32'(e.busy));
            check("tx_valid",  32'(tx_valid),  32'(e.tx_valid));
            check("tx_data",   32'(tx_data),   32'(e.tx_data));
            check("req_ready", 32'(req_ready), 32'(e.req_ready));
            if (tx_valid && tx_ready) begin
                o = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (grant[i]) o = i;
                if (o < 0 || $countones(grant) != 1) begin
                    check("xfer_owner_onehot", 32'(grant), 32'(1));
                end else if (sb[o].size() == 0) begin
                    check("xfer_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    want = sb[o].pop_front();
                    check($sformatf("stream%0d_byte", o), 32'(tx_data), 32'(want));
                    xfers++;
                end
            end
        end
    end

    initial begin
        int stall;
        int rst_left;
        int pause[NREQ];
        int len;
        logic [7:0] ch;
        logic [NREQ-1:0] acc;

        resetn    = 1'b0;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        m_locked  = 1'b0;
        m_last    = NREQ - 1;
        m_owner   = 0;
        m_idle_run = 0;
        m_sent    = 0;
        stall     = 0;
        rst_left  = 0;
        for (int i = 0; i < NREQ; i++) pause[i] = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // occasional mid-run reset, with tx_ready low so no byte is handed over
            if (rst_left == 0 && cyc > 100 && $urandom_range(0, 1999) == 0)
                rst_left = $urandom_range(1, 2);
            resetn = (rst_left == 0);
            if (rst_left > 0) rst_left--;

            if (stall > 0) begin
                tx_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 299) == 0) begin
                tx_ready = 1'b0;
                stall    = 49;
            end else begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end
            if (!resetn) tx_ready = 1'b0;

            for (int i = 0; i < NREQ; i++) begin
                if (src[i].size() == 0 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 6);
                    for (int n = 0; n < len; n++) begin
                        ch = 8'h61 + 8'($urandom_range(0, 25));
                        src[i].push_back(ch);
                        sb[i].push_back(ch);
                    end
                    if ($urandom_range(0, 3) != 0) begin
                        src[i].push_back(EOL);
                        sb[i].push_back(EOL);
                    end
                end
                if (pause[i] > 0) begin
                    pause[i]--;
                    req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 149) == 0) begin
                    pause[i]     = $urandom_range(5, 25);
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = (src[i].size() > 0) && ($urandom_range(0, 4) != 0);
                end
                req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
            end

            model_step(acc);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (acc[i]) void'(src[i].pop_front());
        end

        @(negedge clk);
        check("pending_expectations", 32'(exp_q.size()), 32'(0));
        check("enough_traffic", 32'(xfers > 500), 32'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
